// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: 2-entry stereo PCM FIFO feeding a standard I2S
// serializer clocked by temp_clk_mclk, oversampling sclk_in/lrclk_in.
//
// Ports:
//   temp_clk_mclk  block clock (>= 4x sclk)
//   rst            async active-high reset
//   sclk_in        I2S bit clock, async input
//   lrclk_in       I2S word select, async input (0 = left)
//   in_valid       sample pair offered
//   in_left        left sample (DATA_W)
//   in_right       right sample (DATA_W)
//   in_ready       FIFO not full
//   sdata          serial data, MSB first, one-bit delay
//   frame_start    pulse: pair popped at a left slot start
//   underrun       pulse: FIFO empty at a left slot start
//   underrun_cnt   saturating underrun count
//
// Optional: define I2S_TX_UNDERRUN_CNT_EN to build the underrun
// counter; otherwise underrun_cnt is tied to zero.
module i2s_tx_serializer #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              temp_clk_mclk,
  input  logic              rst,
  input  logic              sclk_in,
  input  logic              lrclk_in,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  output logic              in_ready,
  output logic              sdata,
  output logic              frame_start,
  output logic              underrun,
  output logic [CNT_W-1:0]  underrun_cnt
);

  localparam int KW = $clog2(SLOT_W);
  localparam logic [KW-1:0] K_MAX = KW'(SLOT_W - 1);
  localparam logic [KW-1:0] K_DAT = KW'(DATA_W);

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  // input synchronizers and sclk falling-edge detect
  logic sclk_s1;
  logic sclk_s2;
  logic sclk_d;
  logic lr_s1;
  logic lr_s2;
  logic sclk_fall;

  always_ff @(posedge temp_clk_mclk or posedge rst) begin
    if (rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      lr_s1   <= 1'b0;
      lr_s2   <= 1'b0;
    end else begin
      sclk_s1 <= sclk_in;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      lr_s1   <= lrclk_in;
      lr_s2   <= lr_s1;
    end
  end

  assign sclk_fall = sclk_d & ~sclk_s2;

  // slot boundary detect and bit index
  logic          lr_last;
  logic [KW-1:0] k_q;
  logic [KW-1:0] k_nxt;
  logic          boundary;
  logic          load_l;
  logic          load_r;

  always_comb begin
    boundary = sclk_fall && (lr_s2 != lr_last);
    load_l   = boundary && !lr_s2;
    load_r   = boundary && lr_s2;
    k_nxt    = k_q;
    if (boundary) begin
      k_nxt = '0;
    end else if (k_q != K_MAX) begin
      k_nxt = k_q + 1'b1;
    end
  end

  // FIFO
  pair_t      mem [2];
  pair_t      head;
  logic [1:0] cnt_q;
  logic       wp_q;
  logic       rp_q;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  assign in_ready   = (cnt_q != 2'd2);
  assign fifo_empty = (cnt_q == 2'd0);
  assign push       = in_valid && in_ready;
  assign pop        = load_l && !fifo_empty;
  assign head       = mem[rp_q];

  always_ff @(posedge temp_clk_mclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      cnt_q <= 2'd0;
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
    end else begin
      if (push) begin
        mem[wp_q].l <= in_left;
        mem[wp_q].r <= in_right;
        wp_q        <= ~wp_q;
      end
      if (pop) begin
        rp_q <= ~rp_q;
      end
      unique case (1'b1)
        (push && !pop): cnt_q <= cnt_q + 2'd1;
        (pop && !push): cnt_q <= cnt_q - 2'd1;
        default:        cnt_q <= cnt_q;
      endcase
    end
  end

  // holding registers and output shifter
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] sh_q;
  logic              bit_on;

  // k >= 1 whenever no boundary, so this covers 1..DATA_W
  assign bit_on = !boundary && (k_nxt <= K_DAT);

  always_ff @(posedge temp_clk_mclk or posedge rst) begin
    if (rst) begin
      lr_last     <= 1'b0;
      k_q         <= '0;
      hold_l      <= '0;
      hold_r      <= '0;
      sh_q        <= '0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= pop;
      underrun    <= load_l && fifo_empty;
      if (sclk_fall) begin
        lr_last <= lr_s2;
        k_q     <= k_nxt;
        sdata   <= bit_on ? sh_q[DATA_W-1] : 1'b0;
        if (load_l) begin
          hold_l <= pop ? head.l : '0;
          hold_r <= pop ? head.r : '0;
          sh_q   <= pop ? head.l : '0;
        end else if (load_r) begin
          sh_q <= hold_r;
        end else if (bit_on) begin
          sh_q <= sh_q << 1;
        end
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [CNT_W-1:0] ucnt_q;

  always_ff @(posedge temp_clk_mclk or posedge rst) begin
    if (rst) begin
      ucnt_q <= '0;
    end else if (load_l && fifo_empty && (ucnt_q != '1)) begin
      ucnt_q <= ucnt_q + 1'b1;
    end
  end

  assign underrun_cnt = ucnt_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer: directed bench for i2s_tx_serializer.
// sclk = 8 mclk periods; lrclk changes on sclk falling edges.
module tb_i2s_tx_serializer;

  localparam int DW = 24;
  localparam int SW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b1;
  logic          lrclk = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_left = '0;
  logic [DW-1:0] in_right = '0;
  logic          in_ready;
  logic          sdata;
  logic          frame_start;
  logic          underrun;
  logic [CW-1:0] underrun_cnt;

  int          total = 0;
  int          bad = 0;
  int          fs_n = 0;
  int          ur_n = 0;
  logic [31:0] bits;

  i2s_tx_serializer #(
    .DATA_W(DW),
    .SLOT_W(SW),
    .CNT_W (CW)
  ) dut (
    .temp_clk_mclk(clk),
    .rst          (rst),
    .sclk_in      (sclk),
    .lrclk_in     (lrclk),
    .in_valid     (in_valid),
    .in_left      (in_left),
    .in_right     (in_right),
    .in_ready     (in_ready),
    .sdata        (sdata),
    .frame_start  (frame_start),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_start) fs_n++;
    if (underrun) ur_n++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] ecnt(input int v);
    logic [CW-1:0] r;
    r = CW'(v);
`ifndef I2S_TX_UNDERRUN_CNT_EN
    r = '0;
`endif
    return r;
  endfunction

  function automatic logic [31:0] eslot(input logic [DW-1:0] s);
    return {1'b0, s, 7'b0};
  endfunction

  // n sclk periods; bits collects sdata after each fall, oldest first
  task automatic falls(input logic lr, input int n);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      sclk  = 1'b0;
      lrclk = lr;
      repeat (4) @(negedge clk);
      bits = {bits[30:0], sdata};
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_sdata", 64'(sdata), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_fs", 64'(frame_start), 64'd0);
    chk("rst_ur", 64'(underrun), 64'd0);
    chk("rst_cnt", 64'(underrun_cnt), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // idle frames: underrun every left slot, counter saturates
    falls(1'b1, SW);
    for (int f = 1; f <= 5; f++) begin
      falls(1'b0, SW);
      chk("idle_l", 64'(bits), 64'd0);
      chk("idle_cnt", 64'(underrun_cnt), 64'(ecnt(f > 3 ? 3 : f)));
      falls(1'b1, SW);
      chk("idle_r", 64'(bits), 64'd0);
    end
    chk("idle_urn", 64'(ur_n), 64'd5);
    chk("idle_fsn", 64'(fs_n), 64'd0);
    chk("idle_ready", 64'(in_ready), 64'd1);

    // single pair
    push(24'hA5A5A5, 24'h3C3C3C);
    chk("one_ready", 64'(in_ready), 64'd1);
    falls(1'b0, SW);
    chk("a5_l", 64'(bits), 64'(eslot(24'hA5A5A5)));
    chk("a5_fsn", 64'(fs_n), 64'd1);
    falls(1'b1, SW);
    chk("3c_r", 64'(bits), 64'(eslot(24'h3C3C3C)));
    chk("a5_urn", 64'(ur_n), 64'd5);

    // fill FIFO, hold valid across a pop
    in_valid = 1'b1;
    in_left  = 24'h123456;
    in_right = 24'hABCDEF;
    chk("f1_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_left  = 24'h800001;
    in_right = 24'h7FFFFE;
    chk("f2_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_left  = 24'hFFFFFF;
    in_right = 24'h000001;
    chk("full_ready", 64'(in_ready), 64'd0);
    repeat (5) @(negedge clk);
    chk("full_hold", 64'(in_ready), 64'd0);
    falls(1'b0, SW);
    in_valid = 1'b0;
    chk("p1_l", 64'(bits), 64'(eslot(24'h123456)));
    chk("refull", 64'(in_ready), 64'd0);
    chk("p1_fsn", 64'(fs_n), 64'd2);
    falls(1'b1, SW);
    chk("p1_r", 64'(bits), 64'(eslot(24'hABCDEF)));
    falls(1'b0, SW);
    chk("p2_l", 64'(bits), 64'(eslot(24'h800001)));
    chk("p2_ready", 64'(in_ready), 64'd1);
    falls(1'b1, SW);
    chk("p2_r", 64'(bits), 64'(eslot(24'h7FFFFE)));
    falls(1'b0, SW);
    chk("p3_l", 64'(bits), 64'(eslot(24'hFFFFFF)));
    falls(1'b1, SW);
    chk("p3_r", 64'(bits), 64'(eslot(24'h000001)));
    chk("p3_fsn", 64'(fs_n), 64'd4);
    falls(1'b0, SW);
    chk("dry_l", 64'(bits), 64'd0);
    chk("dry_urn", 64'(ur_n), 64'd6);
    chk("dry_cnt", 64'(underrun_cnt), 64'(ecnt(3)));
    falls(1'b1, SW);
    chk("dry_r", 64'(bits), 64'd0);

    // reset mid left slot at k=10 with a full FIFO
    push(24'hFFFFFF, 24'hFFFFFF);
    push(24'h111111, 24'h222222);
    chk("m_full", 64'(in_ready), 64'd0);
    falls(1'b0, 11);
    chk("m_bits", 64'(bits), 64'h3FF);
    chk("m_fsn", 64'(fs_n), 64'd5);
    push(24'h333333, 24'h444444);
    chk("m_refull", 64'(in_ready), 64'd0);
    chk("m_sdata", 64'(sdata), 64'd1);
    rst = 1'b1;
    #1;
    chk("mr_sdata", 64'(sdata), 64'd0);
    chk("mr_ready", 64'(in_ready), 64'd1);
    chk("mr_cnt", 64'(underrun_cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    falls(1'b1, SW);
    chk("pr_r0", 64'(bits), 64'd0);
    falls(1'b0, SW);
    chk("pr_l", 64'(bits), 64'd0);
    chk("pr_urn", 64'(ur_n), 64'd7);
    chk("pr_fsn", 64'(fs_n), 64'd5);
    chk("pr_cnt", 64'(underrun_cnt), 64'(ecnt(1)));
    falls(1'b1, SW);
    chk("pr_r", 64'(bits), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
